// File: rtl/ula_muldiv.sv
// ula_muldiv: multi-cycle ALU with registered result, iterative multiply/divide into HI/LO and HI/LO moves
//   clk, reset          : clock and synchronous active-high reset
//   start, OP, In1, In2 : request strobe, operation code and operands, sampled together
//   shamt               : immediate shift amount
//   busy, done          : operation in progress / one-cycle completion pulse
//   result, Zero_flag   : registered ALU result and branch flag
//   hi, lo              : architectural HI/LO registers
module ula_muldiv #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       OP,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             Zero_flag,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t             state_q;
    logic [4:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, m_q, result_q, hi_q, lo_q;
    logic [SHW-1:0]     sh_q, cnt_q;
    logic [2*WIDTH-1:0] p_q;
    logic               neg_q, rneg_q, busy_q, done_q, zero_q;
    logic               sgn_i, md_i;
    logic [WIDTH-1:0]   abs_a, abs_b, quo, rem, res_d, hi_d, lo_d;
    logic [WIDTH:0]     sum, t, diff;
    logic [2*WIDTH-1:0] p_mul, p_div, prod;
    logic               zero_d;
    always_comb begin
        sgn_i = ~OP[0];
        md_i  = OP[4:2] == 3'b100;
        abs_a = (sgn_i && In1[WIDTH-1]) ? -In1 : In1;
        abs_b = (sgn_i && In2[WIDTH-1]) ? -In2 : In2;
        // shift-add: conditionally add the multiplicand to the upper half, then shift right
        sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        p_mul = {sum, p_q[WIDTH-1:1]};
        // restoring divide: upper half is the partial remainder, lower half shifts out dividend and in quotient
        t     = p_q[2*WIDTH-1:WIDTH-1];
        diff  = t - {1'b0, m_q};
        p_div = diff[WIDTH] ? {t[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        prod  = neg_q ? -p_q : p_q;
        quo   = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        rem   = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
        res_d = op_q[4] ? result_q : '0;
        hi_d  = hi_q;
        lo_d  = lo_q;
        case (op_q)
            5'h00: res_d = a_q & b_q;
            5'h01: res_d = a_q | b_q;
            5'h02: res_d = a_q + b_q;
            5'h03, 5'h08: res_d = a_q - b_q;
            5'h04: res_d = a_q << b_q[SHW-1:0];
            5'h05: res_d = a_q >> b_q[SHW-1:0];
            5'h06: res_d = $signed(a_q) >>> b_q[SHW-1:0];
            5'h07: res_d = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            5'h09: res_d = a_q << sh_q;
            5'h0A: res_d = a_q >> sh_q;
            5'h0B: res_d = a_q ^ b_q;
            5'h0C: res_d = ~(a_q | b_q);
            5'h0D: res_d = $signed(a_q) >>> sh_q;
            5'h0F: res_d = {{(WIDTH-1){1'b0}}, a_q < b_q};
            5'h10, 5'h11: {hi_d, lo_d} = prod;
            5'h12, 5'h13: begin
                lo_d = (b_q == '0) ? '1 : quo;
                hi_d = (b_q == '0) ? a_q : rem;
            end
            5'h14: res_d = hi_q;
            5'h15: res_d = lo_q;
            5'h16: hi_d = a_q;
            5'h17: lo_d = a_q;
            default: ;
        endcase
        zero_d = (op_q == 5'h08) ? (res_d != '0) : (res_d == '0);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    op_q    <= OP;
                    a_q     <= In1;
                    b_q     <= In2;
                    sh_q    <= shamt;
                    cnt_q   <= '0;
                    neg_q   <= sgn_i & (In1[WIDTH-1] ^ In2[WIDTH-1]);
                    rneg_q  <= sgn_i & In1[WIDTH-1];
                    p_q     <= {{WIDTH{1'b0}}, OP[1] ? abs_a : abs_b};
                    m_q     <= OP[1] ? abs_b : abs_a;
                    busy_q  <= md_i;
                    state_q <= md_i ? RUN : FIN;
                end
                RUN: begin
                    p_q   <= op_q[1] ? p_div : p_mul;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SHW'(WIDTH-1)) state_q <= FIN;
                end
                FIN: begin
                    result_q <= res_d;
                    zero_q   <= zero_d;
                    hi_q     <= hi_d;
                    lo_q     <= lo_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign Zero_flag = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_ula_muldiv.sv
// tb_ula_muldiv: directed self-checking bench for ula_muldiv at WIDTH=32 and WIDTH=16
module tb_ula_muldiv;
    logic        clk = 0, reset = 1, go = 0, ws = 0;
    logic [4:0]  op = 0, sh = 0;
    logic [31:0] a = 0, b = 0;
    logic        busy32, done32, zf32, busy16, done16, zf16;
    logic [31:0] res32, hi32, lo32;
    logic [15:0] res16, hi16, lo16;
    logic        busy_s, done_s;
    int          checks = 0, errors = 0;
    always #5 clk = ~clk;
    assign busy_s = ws ? busy16 : busy32;
    assign done_s = ws ? done16 : done32;
    ula_muldiv #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .start(go & ~ws), .OP(op), .In1(a), .In2(b), .shamt(sh),
        .busy(busy32), .done(done32), .result(res32), .Zero_flag(zf32), .hi(hi32), .lo(lo32)
    );
    ula_muldiv #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .start(go & ws), .OP(op), .In1(a[15:0]), .In2(b[15:0]), .shamt(sh[3:0]),
        .busy(busy16), .done(done16), .result(res16), .Zero_flag(zf16), .hi(hi16), .lo(lo16)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic run(input bit sel, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] s, input int lat_e, input bit inj);
        int lat;
        @(negedge clk);
        ws = sel; op = o; a = x; b = y; sh = s; go = 1;
        @(posedge clk); #1 go = 0;
        chk("busy", busy_s, lat_e > 1);
        lat = 0;
        while (!done_s && lat < 100) begin
            if (inj && lat == 4) begin
                go = 1;
                op = 5'h02;
            end
            @(posedge clk); #1 go = 0;
            lat++;
        end
        chk("latency", lat, lat_e);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_res", res32, 0);
        chk("rst_zf", zf32, 0);
        chk("rst_hi", hi32, 0);
        chk("rst_lo", lo32, 0);
        reset = 0;
        run(0, 5'h02, 5, 7, 0, 1, 0);
        chk("add", res32, 12);
        chk("add_zf", zf32, 0);
        run(0, 5'h08, 9, 9, 0, 1, 0);
        chk("bne_eq", res32, 0);
        chk("bne_eq_zf", zf32, 0);
        run(0, 5'h08, 9, 4, 0, 1, 0);
        chk("bne_ne", res32, 5);
        chk("bne_ne_zf", zf32, 1);
        run(0, 5'h07, 32'hFFFFFFFF, 1, 0, 1, 0);
        chk("slt", res32, 1);
        run(0, 5'h0F, 32'hFFFFFFFF, 1, 0, 1, 0);
        chk("sltu", res32, 0);
        chk("sltu_zf", zf32, 1);
        run(0, 5'h0D, 32'h80000000, 0, 4, 1, 0);
        chk("sra", res32, 32'hF8000000);
        run(0, 5'h04, 1, 32'h21, 0, 1, 0);
        chk("sllv", res32, 2);
        run(0, 5'h03, 3, 5, 0, 1, 0);
        chk("sub_wrap", res32, 32'hFFFFFFFE);
        run(0, 5'h0C, 0, 0, 0, 1, 0);
        chk("nor", res32, 32'hFFFFFFFF);
        run(0, 5'h0A, 32'h80000000, 0, 31, 1, 0);
        chk("srl", res32, 1);
        run(0, 5'h06, 32'h80000000, 32'h3F, 0, 1, 0);
        chk("srav", res32, 32'hFFFFFFFF);
        run(0, 5'h0B, 32'hF0F0, 32'hFF00, 0, 1, 0);
        chk("xor", res32, 32'h0FF0);
        run(0, 5'h0E, 1, 2, 0, 1, 0);
        chk("unused", res32, 0);
        chk("unused_zf", zf32, 1);
        run(0, 5'h02, 1, 2, 0, 1, 0);
        run(0, 5'h10, 32'hFFFFFFFD, 7, 0, 33, 0);
        chk("mult_hi", hi32, 32'hFFFFFFFF);
        chk("mult_lo", lo32, 32'hFFFFFFEB);
        chk("mult_res", res32, 3);
        run(0, 5'h11, 32'hFFFFFFFF, 2, 0, 33, 1);
        chk("multu_hi", hi32, 1);
        chk("multu_lo", lo32, 32'hFFFFFFFE);
        chk("ignored_start_res", res32, 3);
        @(posedge clk); #1;
        chk("no_queue_done", done32, 0);
        run(0, 5'h12, 32'hFFFFFFF9, 2, 0, 33, 0);
        chk("div_lo", lo32, 32'hFFFFFFFD);
        chk("div_hi", hi32, 32'hFFFFFFFF);
        run(0, 5'h13, 100, 0, 0, 33, 0);
        chk("divu0_lo", lo32, 32'hFFFFFFFF);
        chk("divu0_hi", hi32, 100);
        run(0, 5'h12, 32'h80000000, 32'hFFFFFFFF, 0, 33, 0);
        chk("divmin_lo", lo32, 32'h80000000);
        chk("divmin_hi", hi32, 0);
        run(0, 5'h13, 1000, 7, 0, 33, 0);
        chk("divu_lo", lo32, 142);
        chk("divu_hi", hi32, 6);
        run(0, 5'h16, 32'h1234, 0, 0, 1, 0);
        chk("mthi", hi32, 32'h1234);
        chk("mthi_res", res32, 3);
        run(0, 5'h14, 0, 0, 0, 1, 0);
        chk("mfhi", res32, 32'h1234);
        run(0, 5'h17, 32'h55AA, 0, 0, 1, 0);
        run(0, 5'h15, 0, 0, 0, 1, 0);
        chk("mflo", res32, 32'h55AA);
        @(negedge clk);
        ws = 0; op = 5'h11; a = 3; b = 3; go = 1;
        @(negedge clk); go = 0;
        repeat (5) @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        chk("abort_busy", busy32, 0);
        chk("abort_hi", hi32, 0);
        chk("abort_lo", lo32, 0);
        chk("abort_res", res32, 0);
        reset = 0;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", done32, 0);
        chk("abort_lo_hold", lo32, 0);
        run(1, 5'h11, 32'hFFFF, 32'hFFFF, 0, 17, 0);
        chk("w16_hi", hi16, 16'hFFFE);
        chk("w16_lo", lo16, 16'h0001);
        run(1, 5'h02, 32'hFFFF, 2, 0, 1, 0);
        chk("w16_add", res16, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ula_muldiv.md
Name: ula_muldiv

Overview:
- Parametrised, multi-cycle successor of the processor's ALU.
- Performs all single-cycle ALU operations with a registered result.
- Adds iterative signed/unsigned multiply and divide into architectural HI/LO registers, plus HI/LO move operations.
- Sits in the execute stage; the control unit stalls the datapath while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; OP, In1, In2 and shamt are sampled on this edge
- OP  input  5  operation code
- In1  input  WIDTH  operand A (rs)
- In2  input  WIDTH  operand B (rt, or shift amount for variable shifts)
- shamt  input  SHW  immediate shift amount
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: result, Zero_flag and HI/LO are valid
- result  output  WIDTH  registered result
- Zero_flag  output  1  branch flag
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high): busy=0, done=0, result=0, Zero_flag=0, hi=0, lo=0, FSM=IDLE. Reset aborts any operation in progress; no partial result is written.
- FSM states: IDLE, RUN, FIN.
  - IDLE: on start, latch the inputs.
  - Single-cycle ops go directly to FIN.
  - MULT/MULTU/DIV/DIVU go to RUN with busy=1 and iteration counter=0.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, for WIDTH cycles. Then go to FIN.
  - FIN: drive done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency:
  - Single-cycle ops: done on edge N+1 after the start edge N.
  - MULT/DIV family: done on edge N+WIDTH+1. busy is high on edges N+1 through N+WIDTH.
- start while busy=1 or in FIN is ignored; no queueing.
- result holds its value until the next completed op. HI/LO ops and MULT/DIV leave result unchanged.
- OP codes, single-cycle (result only):
  - 00 and; 01 or; 02 add; 03 sub; 08 sub (bne).
  - 04 sllv; 05 srlv; 06 srav; variable shifts use In2[SHW-1:0].
  - 07 slt (signed); 0F sltu (unsigned).
  - 09 sll by shamt; 0A srl by shamt; 0D sra by shamt.
  - 0B xor; 0C nor.
  - Unused codes: result=0.
- Arithmetic: add/sub wrap modulo 2^WIDTH; no overflow trap.
- OP codes, HI/LO:
  - 10 MULT (signed), 11 MULTU: {hi,lo} = full 2*WIDTH product.
  - 12 DIV (signed), 13 DIVU: lo=quotient, hi=remainder.
  - 14 MFHI: result=hi. 15 MFLO: result=lo.
  - 16 MTHI: hi=In1. 17 MTLO: lo=In1.
- Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
- Division edge cases:
  - Divide by zero: completes at normal latency, lo=all ones, hi=In1.
  - DIV of most-negative by -1: lo=most-negative, hi=0.
- Zero_flag, updated only on done:
  - OP 08: (result != 0).
  - All other ops: (result == 0), evaluated on the new result.
- hi/lo update on the done edge only. They are unchanged while busy.

Test Plan:
- Reset, then add: start with OP=02, In1=5, In2=7 -> done one cycle later, result=12, Zero_flag=0. Assert reset mid-MULT -> busy=0, hi=lo=0 on the next edge.
- bne and slt: OP=08, In1=In2=9 -> result=0, Zero_flag=0. OP=08 with 9 vs 4 -> Zero_flag=1. OP=07 with -1 vs 1 -> result=1. OP=0F with 0xFFFFFFFF vs 1 -> result=0.
- Shifts: OP=0D, In1=0x80000000, shamt=4 -> 0xF8000000. OP=04, In1=1, In2=0x21 -> result=2 (only 5 bits of In2 used).
- MULT: In1=-3, In2=7 -> done at N+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF x 2 -> hi=1, lo=0xFFFFFFFE. start pulsed while busy -> ignored.
- Divide: DIV -7/2 -> lo=-3, hi=-1. DIVU 100/0 -> lo=0xFFFFFFFF, hi=100. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- HI/LO moves: MTHI 0x1234, then MFHI -> result=0x1234. Repeat with WIDTH=16 -> MULTU 0xFFFF x 0xFFFF gives hi=0xFFFE, lo=0x0001, done at N+17.
